// File: rtl/dice_light_monitor_if.sv
// Result bus from the dice/light multiplexer: a valid strobe, a source tag and a 3-bit value.
interface dice_light_monitor_if;
    logic       in_valid;
    logic       sel;
    logic [2:0] result;

    modport master (output in_valid, sel, result);
    modport slave  (input  in_valid, sel, result);
endinterface

// File: rtl/dice_light_monitor.sv
// Demultiplexes the dice/traffic-light result bus, checks dice range and light sequence order,
// and drives a registered seven-segment display plus saturating error statistics.
module dice_light_monitor #(
    parameter bit          ALLOW_HOLD = 1'b1,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dice_light_monitor_if.slave  bus,
    output logic [2:0]           dice_val,
    output logic [2:0]           light_val,
    output logic                 dice_err,
    output logic                 light_err,
    output logic                 err_sticky,
    output logic [ERR_W-1:0]     err_count,
    output logic [6:0]           seg
);

    typedef enum logic [0:0] {StResync, StTrack} state_e;

    localparam logic [6:0] SegDash = 7'b0000001;
    localparam logic [6:0] SegOne  = 7'b0110000;

    state_e           state_q, state_d;
    logic [2:0]       dice_val_q, dice_val_d;
    logic [2:0]       light_val_q, light_val_d;
    logic             dice_err_q, dice_err_d;
    logic             light_err_q, light_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [6:0]       seg_q, seg_d;
    logic             src_q, src_d;
    logic             any_err;

    function automatic logic light_legal(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b110) || (c == 3'b001) || (c == 3'b010);
    endfunction

    function automatic logic [2:0] light_next(input logic [2:0] c);
        case (c)
            3'b100:  return 3'b110;
            3'b110:  return 3'b001;
            3'b001:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [6:0] dice_seg(input logic [2:0] d);
        case (d)
            3'd1:    return 7'b0110000;
            3'd2:    return 7'b1101101;
            3'd3:    return 7'b1111001;
            3'd4:    return 7'b0110011;
            3'd5:    return 7'b1011011;
            3'd6:    return 7'b1011111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Light code {red, amber, green} maps onto segments a, g and d.
    function automatic logic [6:0] light_seg(input logic [2:0] c);
        return {c[2], 2'b00, c[0], 2'b00, c[1]};
    endfunction

    always_comb begin
        state_d     = state_q;
        dice_val_d  = dice_val_q;
        light_val_d = light_val_q;
        src_d       = src_q;
        dice_err_d  = 1'b0;
        light_err_d = 1'b0;
        if (bus.in_valid) begin
            src_d = bus.sel;
            if (!bus.sel) begin
                // Lights run unobserved while the dice are selected.
                state_d = StResync;
                if (bus.result == 3'b000 || bus.result == 3'b111) begin
                    dice_err_d = 1'b1;
                end else begin
                    dice_val_d = bus.result;
                end
            end else if (!light_legal(bus.result)) begin
                light_err_d = 1'b1;
                state_d     = StResync;
            end else begin
                light_val_d = bus.result;
                state_d     = StTrack;
                unique case (state_q)
                    StResync: ;
                    StTrack: begin
                        if (bus.result != light_next(light_val_q) &&
                            !(ALLOW_HOLD && bus.result == light_val_q)) begin
                            light_err_d = 1'b1;
                        end
                    end
                endcase
            end
        end

        any_err      = dice_err_d | light_err_d;
        err_sticky_d = err_sticky_q | any_err;
        err_count_d  = err_count_q;
        if (any_err && err_count_q != {ERR_W{1'b1}}) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        if (any_err)    seg_d = SegDash;
        else if (src_d) seg_d = light_seg(light_val_d);
        else            seg_d = dice_seg(dice_val_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StResync;
            dice_val_q   <= 3'd1;
            light_val_q  <= 3'b100;
            dice_err_q   <= 1'b0;
            light_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            seg_q        <= SegOne;
            src_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dice_val_q   <= dice_val_d;
            light_val_q  <= light_val_d;
            dice_err_q   <= dice_err_d;
            light_err_q  <= light_err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            seg_q        <= seg_d;
            src_q        <= src_d;
        end
    end

    assign dice_val   = dice_val_q;
    assign light_val  = light_val_q;
    assign dice_err   = dice_err_q;
    assign light_err  = light_err_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign seg        = seg_q;

endmodule

// File: doc/dice_light_monitor.md
Name: dice_light_monitor

Overview:
- Receiving end of the 3-bit dice/traffic-light result bus.
- Samples `result[2:0]` together with `sel`, demultiplexes the two sources into held registers, and checks each source's legality: dice face range and traffic-light sequence order.
- Drives a registered seven-segment pattern for the currently selected source and a saturating error counter.
- Sits between the dice/light multiplexer and the board display/LED logic.

Parameters:
- ALLOW_HOLD, 1, when 1 a traffic-light sample equal to the previous light sample is legal; when 0 it is a sequence error.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising clk.
- in_valid  input  1  result/sel are sampled on a rising edge where in_valid=1.
- sel  input  1  source tag: 0 = dice, 1 = traffic lights.
- result  input  3  multiplexed bus; lights encoded {red, amber, green}.
- dice_val  output  3  last accepted legal dice value.
- light_val  output  3  last accepted legal light code.
- dice_err  output  1  one-cycle pulse: illegal dice sample.
- light_err  output  1  one-cycle pulse: illegal light code or illegal transition.
- err_sticky  output  1  set by any error, cleared only by reset.
- err_count  output  ERR_W  count of error samples, saturating at all-ones.
- seg  output  7  active-high segments {a..g} for the displayed value.

Behaviour:
- Reset (rst=0 at an edge):
  - dice_val=3'd1, light_val=3'b100 (red), all error outputs 0, err_count=0, seg=pattern for "1".
  - Internal light FSM goes to RESYNC.
- Samples with in_valid=0 change nothing, and dice_err/light_err are 0 that cycle.
- All outputs are registered. A sample accepted at edge N is reflected on outputs after edge N, with no further latency.
- Dice path (sel=0):
  - result in 1..6 → dice_val<=result.
  - result 3'b000 or 3'b111 → dice_err=1 and dice_val holds.
  - A dice sample forces the light FSM to RESYNC, because the lights run unobserved while deselected.
- Light path (sel=1):
  - Legal codes are 100 (R), 110 (RA), 001 (G), 010 (A). Any other code → light_err=1, light_val holds, FSM goes to RESYNC.
  - FSM states: RESYNC, TRACK.
  - In RESYNC, any legal code is accepted, light_val<=code, FSM→TRACK.
  - In TRACK, the legal successors are R→RA, RA→G, G→A, A→R, plus same-code if ALLOW_HOLD=1.
  - A legal successor → light_val<=code, FSM stays in TRACK.
  - A legal code that is an illegal successor → light_err=1, light_val<=code (resynchronise on it), FSM stays in TRACK.
- Errors:
  - err_count increments by 1 per sample where dice_err or light_err is asserted; at most one increment per edge.
  - err_count holds at 2^ERR_W-1 once it saturates.
  - err_sticky<=1 on any error.
- Display:
  - When the last accepted sample had sel=0, seg shows the decimal digit of dice_val using standard patterns: 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111.
  - When the last accepted sample had sel=1, seg shows a=red, g=amber, d=green.
  - On an error sample, seg shows the dash pattern 0000001 for that cycle only, then reverts.
- Reset mid-sequence:
  - Takes priority over in_valid, and a sample on the reset edge is discarded.
  - The first light sample after reset is never a transition error.

Test Plan:
- Reset, then dice samples 1,2,3,4,5,6 (sel=0, in_valid=1) → dice_val follows each 1 cycle later; seg shows 0110000…1011111; no errors.
- Dice samples 000 then 111 → dice_err pulses twice, dice_val stays 6, err_count=2, err_sticky=1.
- Light sequence 100,110,001,010,100 (sel=1) → no light_err; light_val follows; seg a/g/d bits track red/amber/green.
- TRACK in state G, inject 100 → light_err=1, light_val=100, err_count+1; then 110 → legal, no error.
- Light 011 → light_err, FSM RESYNC; then 001 → accepted without error.
- Mixed sel: light 110, dice 3, light 010 → no error (dice forced RESYNC).
- With ERR_W=2, inject 5 errors → err_count stops at 3.
- Assert rst=0 mid-stream with in_valid=1 → all outputs at reset values next cycle.
